arp_resolver: RTL and testbench

Resolves next-hop IPv4 addresses to MAC addresses for the IP transmit path. It serves the IP block's ARP request/response handshake from a small fully-associative cache. On a miss it asks the ARP frame transmitter to broadcast a query, retries on timeout, and finally reports an error. Cache contents are learned from an update strobe driven by the ARP frame receiver.

---
 rtl/arp_resolver.sv | 237 +++++++++++++++++++++++
 tb/tb_arp_resolver.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_resolver.sv
`default_nettype none
// ============================================================================
// Module   : arp_resolver
// Function : IPv4 next-hop to MAC resolution with a round-robin ARP cache,
//            query retries and timeout error. Option: ARP_RESOLVER_GATEWAY_EN.
// Revision : 1.0
// ============================================================================
module arp_resolver #(
  parameter int CACHE_ENTRIES  = 4,
  parameter int RETRY_COUNT    = 4,
  parameter int RETRY_INTERVAL = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arp_request_valid,
  output logic        arp_request_ready,
  input  logic [31:0] arp_request_ip,
  output logic        arp_response_valid,
  input  logic        arp_response_ready,
  output logic        arp_response_error,
  output logic [47:0] arp_response_mac,
  output logic        query_valid,
  input  logic        query_ready,
  output logic [31:0] query_ip,
  input  logic        update_valid,
  input  logic [31:0] update_ip,
  input  logic [47:0] update_mac,
  input  logic        clear_cache,
  input  logic [31:0] local_ip,
  input  logic [31:0] gateway_ip,
  input  logic [31:0] subnet_mask,
  output logic        busy
);

  localparam int IDX_W = $clog2(CACHE_ENTRIES);
  localparam int RTY_W = $clog2(RETRY_COUNT + 1);
  localparam int TMR_W = $clog2(RETRY_INTERVAL);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOOKUP  = 3'd1;
  localparam logic [2:0] S_QUERY   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_RESPOND = 3'd4;

  localparam logic [RTY_W-1:0] RETRY_LOAD = RTY_W'(RETRY_COUNT);
  localparam logic [TMR_W-1:0] TIMER_LOAD = TMR_W'(RETRY_INTERVAL - 1);

  logic [2:0]       r_state, w_state_nxt;
  logic [31:0]      r_target, w_target_nxt;
  logic [RTY_W-1:0] r_retry, w_retry_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [47:0]      w_mac_nxt;
  logic             w_err_nxt;

  logic             w_req_ready_nxt, w_resp_valid_nxt, w_query_valid_nxt, w_busy_nxt;

  logic [CACHE_ENTRIES-1:0] r_valid;
  logic [31:0]              r_ip  [CACHE_ENTRIES];
  logic [47:0]              r_mac [CACHE_ENTRIES];
  logic [IDX_W-1:0]         r_ptr;

  logic             w_hit;
  logic [47:0]      w_hit_mac;
  logic             w_upd_present;
  logic [IDX_W-1:0] w_upd_idx;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_upd_write;

  logic        w_req_fire, w_query_fire, w_resp_fire, w_upd_match, w_bcast;
  logic [31:0] w_resolved_ip;

  assign w_req_fire   = arp_request_valid && arp_request_ready;
  assign w_query_fire = query_valid && query_ready;
  assign w_resp_fire  = arp_response_valid && arp_response_ready;
  assign w_upd_match  = update_valid && (update_ip == r_target);
  assign w_bcast      = (arp_request_ip == 32'hFFFF_FFFF) ||
                        ((arp_request_ip & ~subnet_mask) == ~subnet_mask);

`ifdef ARP_RESOLVER_GATEWAY_EN
  // Off-subnet destinations are resolved through the default gateway.
  assign w_resolved_ip = ((arp_request_ip & subnet_mask) != (local_ip & subnet_mask)) ?
                         gateway_ip : arp_request_ip;
`else
  logic w_unused_cfg;
  assign w_unused_cfg  = ^{local_ip, gateway_ip};
  assign w_resolved_ip = arp_request_ip;
`endif

  // Parallel compare of the lookup key and the learned IP against every entry.
  always_comb begin
    w_hit         = 1'b0;
    w_hit_mac     = '0;
    w_upd_present = 1'b0;
    w_upd_idx     = '0;
    for (int i = 0; i < CACHE_ENTRIES; i++) begin
      if (r_valid[i] && (r_ip[i] == r_target)) begin
        w_hit     = 1'b1;
        w_hit_mac = r_mac[i];
      end
      if (r_valid[i] && (r_ip[i] == update_ip)) begin
        w_upd_present = 1'b1;
        w_upd_idx     = IDX_W'(i);
      end
    end
  end

  assign w_upd_write = update_valid && (update_ip != 32'd0);
  assign w_wr_idx    = w_upd_present ? w_upd_idx : r_ptr;

  always_ff @(posedge clk) begin
    if (rst || clear_cache) begin
      r_valid <= '0;
      r_ptr   <= '0;
    end else if (w_upd_write && !w_upd_present) begin
      r_valid[r_ptr] <= 1'b1;
      r_ptr          <= r_ptr + 1'b1;
    end
  end

  // Entry payload needs no reset: a cleared valid bit hides stale contents.
  always_ff @(posedge clk) begin
    if (w_upd_write && !clear_cache) begin
      r_ip[w_wr_idx]  <= update_ip;
      r_mac[w_wr_idx] <= update_mac;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      r_retry  <= '0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_retry  <= w_retry_nxt;
      r_timer  <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_retry_nxt  = r_retry;
    w_timer_nxt  = r_timer;
    w_mac_nxt    = arp_response_mac;
    w_err_nxt    = arp_response_error;
    case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          if (w_bcast) begin
            w_target_nxt = arp_request_ip;
            w_mac_nxt    = 48'hFFFF_FFFF_FFFF;
            w_err_nxt    = 1'b0;
            w_state_nxt  = S_RESPOND;
          end else begin
            w_target_nxt = w_resolved_ip;
            w_state_nxt  = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_mac_nxt   = w_hit_mac;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RESPOND;
        end else begin
          w_retry_nxt = RETRY_LOAD;
          w_state_nxt = S_QUERY;
        end
      end
      S_QUERY: begin
        if (w_upd_match) begin
          w_mac_nxt   = update_mac;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RESPOND;
        end else if (w_query_fire) begin
          w_retry_nxt = r_retry - 1'b1;
          w_timer_nxt = TIMER_LOAD;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_upd_match) begin
          w_mac_nxt   = update_mac;
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RESPOND;
        end else if (r_timer == '0) begin
          if (r_retry != '0) begin
            w_state_nxt = S_QUERY;
          end else begin
            w_mac_nxt   = '0;
            w_err_nxt   = 1'b1;
            w_state_nxt = S_RESPOND;
          end
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      S_RESPOND: begin
        if (w_resp_fire) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they track the state exactly.
  always_comb begin
    w_req_ready_nxt   = (w_state_nxt == S_IDLE);
    w_resp_valid_nxt  = (w_state_nxt == S_RESPOND);
    w_query_valid_nxt = (w_state_nxt == S_QUERY);
    w_busy_nxt        = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arp_request_ready  <= 1'b0;
      arp_response_valid <= 1'b0;
      arp_response_error <= 1'b0;
      arp_response_mac   <= '0;
      query_valid        <= 1'b0;
      query_ip           <= '0;
      busy               <= 1'b0;
    end else begin
      arp_request_ready  <= w_req_ready_nxt;
      arp_response_valid <= w_resp_valid_nxt;
      arp_response_error <= w_err_nxt;
      arp_response_mac   <= w_mac_nxt;
      query_valid        <= w_query_valid_nxt;
      query_ip           <= w_target_nxt;
      busy               <= w_busy_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arp_resolver.sv
`default_nettype none
// Testbench for arp_resolver: directed and randomized requests scored against an
// insertion-ordered ARP cache model; a negedge monitor checks responses and queries.
module tb_arp_resolver;
  localparam int CE = 4;
  localparam int RC = 2;
  localparam int RI = 16;
  localparam logic [31:0] MASK  = 32'hFFFF_FF00;
  localparam logic [31:0] LOCAL = 32'hC0A8_010A;
  localparam logic [31:0] GW    = 32'hC0A8_0101;

  logic        clk, rst;
  logic        arp_request_valid, arp_request_ready;
  logic [31:0] arp_request_ip;
  logic        arp_response_valid, arp_response_ready, arp_response_error;
  logic [47:0] arp_response_mac;
  logic        query_valid, query_ready;
  logic [31:0] query_ip;
  logic        update_valid;
  logic [31:0] update_ip;
  logic [47:0] update_mac;
  logic        clear_cache;
  logic [31:0] local_ip, gateway_ip, subnet_mask;
  logic        busy;

  arp_resolver #(.CACHE_ENTRIES(CE), .RETRY_COUNT(RC), .RETRY_INTERVAL(RI)) dut (
    .clk(clk), .rst(rst),
    .arp_request_valid(arp_request_valid), .arp_request_ready(arp_request_ready),
    .arp_request_ip(arp_request_ip),
    .arp_response_valid(arp_response_valid), .arp_response_ready(arp_response_ready),
    .arp_response_error(arp_response_error), .arp_response_mac(arp_response_mac),
    .query_valid(query_valid), .query_ready(query_ready), .query_ip(query_ip),
    .update_valid(update_valid), .update_ip(update_ip), .update_mac(update_mac),
    .clear_cache(clear_cache), .local_ip(local_ip), .gateway_ip(gateway_ip),
    .subnet_mask(subnet_mask), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference cache: oldest-inserted entry is evicted, overwrites keep their age.
  logic [31:0] m_ip[$];
  logic [47:0] m_mac[$];

  function automatic void model_learn(input logic [31:0] ip, input logic [47:0] mac);
    if (ip == 32'd0) return;
    foreach (m_ip[i]) if (m_ip[i] == ip) begin m_mac[i] = mac; return; end
    if (m_ip.size() == CE) begin void'(m_ip.pop_front()); void'(m_mac.pop_front()); end
    m_ip.push_back(ip);
    m_mac.push_back(mac);
  endfunction

  function automatic logic model_lookup(input logic [31:0] ip, output logic [47:0] mac);
    mac = '0;
    foreach (m_ip[i]) if (m_ip[i] == ip) begin mac = m_mac[i]; return 1'b1; end
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] ip);
`ifdef ARP_RESOLVER_GATEWAY_EN
    if ((ip & MASK) != (LOCAL & MASK)) return GW;
`endif
    return ip;
  endfunction

  function automatic logic [47:0] rand_mac();
    logic [31:0] a, b;
    a = $urandom;
    b = $urandom;
    return {a[15:0], b};
  endfunction

  // Scoreboard. kind: 0 broadcast, 1 cache hit, 2 answered by update, 3 retries exhausted.
  logic [47:0] exp_mac[$];
  logic        exp_err[$];
  int          exp_kind[$];

  int          last_req = 0, last_q = 0, last_upd = 0;
  int          txn_q = 0, q_total = 0, resp_cnt = 0;
  logic        resp_active = 1'b0, resp_known = 1'b0, q_prev = 1'b0;
  logic [47:0] held_mac = '0;
  logic        held_err = 1'b0;
  logic [31:0] cur_target = '0;

  always @(negedge clk) begin : monitor
    logic [47:0] m;
    logic        e;
    int          k, lat;
    if (rst) begin
      resp_active = 1'b0;
      q_prev      = 1'b0;
    end else begin
      if (arp_request_valid && arp_request_ready) last_req = cyc;
      if (update_valid && update_ip == cur_target) last_upd = cyc;
      if (query_valid) begin
        check("query_ip", 64'(query_ip), 64'(cur_target));
        if (!q_prev) begin
          if (txn_q == 0) check("query_latency", 64'(cyc - last_req), 64'(2));
          else            check("query_spacing", 64'(cyc - last_q), 64'(RI + 1));
        end
        if (query_ready) begin last_q = cyc; txn_q++; q_total++; end
      end
      q_prev = query_valid && !query_ready;
      if (arp_response_valid) begin
        if (!resp_active) begin
          resp_active = 1'b1;
          resp_cnt++;
          if (exp_mac.size() == 0) begin
            checks++;
            failures++;
            resp_known = 1'b0;
            $display("FAIL unexpected_response: actual=mac %0h required=none", arp_response_mac);
          end else begin
            m = exp_mac.pop_front();
            e = exp_err.pop_front();
            k = exp_kind.pop_front();
            held_mac = m;
            held_err = e;
            resp_known = 1'b1;
            check("resp_mac", 64'(arp_response_mac), 64'(m));
            check("resp_err", 64'(arp_response_error), 64'(e));
            check("busy_in_respond", 64'(busy), 64'(1));
            case (k)
              0:       lat = cyc - last_req - 1;
              1:       lat = cyc - last_req - 2;
              2:       lat = cyc - last_upd - 1;
              default: lat = cyc - last_q - (RI + 1);
            endcase
            check("resp_latency_offset", 64'(lat), 64'(0));
          end
        end else if (resp_known) begin
          check("resp_hold_mac", 64'(arp_response_mac), 64'(held_mac));
          check("resp_hold_err", 64'(arp_response_error), 64'(held_err));
        end
        if (arp_response_ready) resp_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=timeout required=event", name);
    exp_mac.delete();
    exp_err.delete();
    exp_kind.delete();
  endtask

  task automatic pulse(input logic upd, input logic [31:0] ip, input logic [47:0] mac,
                       input logic clr);
    update_valid = upd;
    update_ip    = ip;
    update_mac   = mac;
    clear_cache  = clr;
    tick();
    update_valid = 1'b0;
    clear_cache  = 1'b0;
    if (clr) begin m_ip.delete(); m_mac.delete(); end
    else if (upd) model_learn(ip, mac);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", 64'(arp_request_ready), 64'(0));
    check("rst_resp_valid", 64'(arp_response_valid), 64'(0));
    check("rst_resp_err", 64'(arp_response_error), 64'(0));
    check("rst_resp_mac", 64'(arp_response_mac), 64'(0));
    check("rst_query_valid", 64'(query_valid), 64'(0));
    check("rst_query_ip", 64'(query_ip), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
  endtask

  task automatic release_reset();
    rst = 1'b0;
    @(negedge clk);
    check("ready_before_rise", 64'(arp_request_ready), 64'(0));
    @(negedge clk);
    check("ready_after_rise", 64'(arp_request_ready), 64'(1));
    tick();
  endtask

  // mode: 0 no reply, 1 reply d cycles into WAIT, 2 reply while query is pending.
  task automatic request(input logic [31:0] ip, input int mode, input int rdelay,
                         input logic [47:0] rmac);
    logic        bc, hit;
    logic [47:0] hmac;
    logic [31:0] tgt;
    int          expq, n;
    bc  = (ip == 32'hFFFF_FFFF) || ((ip & ~MASK) == ~MASK);
    tgt = bc ? ip : model_target(ip);
    hit = model_lookup(tgt, hmac);
    cur_target = tgt;
    txn_q = 0;
    if (bc) begin
      exp_mac.push_back(48'hFFFF_FFFF_FFFF); exp_err.push_back(1'b0); exp_kind.push_back(0);
      expq = 0;
    end else if (hit) begin
      exp_mac.push_back(hmac); exp_err.push_back(1'b0); exp_kind.push_back(1);
      expq = 0;
    end else if (mode == 0) begin
      exp_mac.push_back(48'd0); exp_err.push_back(1'b1); exp_kind.push_back(3);
      expq = RC;
    end else begin
      exp_mac.push_back(rmac); exp_err.push_back(1'b0); exp_kind.push_back(2);
      expq = (mode == 1) ? 1 : 0;
    end
    if (mode == 2) query_ready = 1'b0;
    arp_request_ip = ip;
    arp_request_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arp_request_ready && n < 100);
    if (!arp_request_ready) begin
      timeout("req_accept");
      arp_request_valid = 1'b0;
      query_ready = 1'b1;
      tick();
      return;
    end
    tick();
    arp_request_valid = 1'b0;
    if (!bc && !hit && mode != 0) begin
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(query_valid && (query_ready || mode == 2)) && n < 100);
      if (!query_valid) timeout("query_wait");
      tick();
      if (mode == 1) repeat ($urandom_range(0, RI - 4)) tick();
      pulse(1'b1, tgt, rmac, 1'b0);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!arp_response_valid && n < 200);
    if (!arp_response_valid) begin
      timeout("resp_wait");
      tick();
    end else begin
      repeat (rdelay) @(negedge clk);
      tick();
      arp_response_ready = 1'b1;
      tick();
      arp_response_ready = 1'b0;
    end
    query_ready = 1'b1;
    check("query_count", 64'(txn_q), 64'(expq));
    check("busy_after_txn", 64'(busy), 64'(0));
  endtask

  localparam logic [31:0] NET = 32'hC0A8_0100;

  initial begin
    int q0, r0, n;
    logic [31:0] ip;
    logic [47:0] mac;
    rst = 1'b1;
    arp_request_valid = 1'b0; arp_request_ip = '0; arp_response_ready = 1'b0;
    query_ready = 1'b1; update_valid = 1'b0; update_ip = '0; update_mac = '0;
    clear_cache = 1'b0; local_ip = LOCAL; gateway_ip = GW; subnet_mask = MASK;
    repeat (3) tick();
    check_reset_outputs();
    release_reset();

    request(NET + 32'd255, 0, 0, '0);                          // directed broadcast
    request(32'hFFFF_FFFF, 0, 1, '0);                          // limited broadcast
    request(NET + 32'd20, 1, 0, 48'h0200_0000_0014);           // miss, learned by reply
    request(NET + 32'd20, 1, 0, '0);                           // hit
    request(NET + 32'd30, 0, 0, '0);                           // retries exhausted
    request(32'h0A00_0005, 1, 0, 48'h0200_0000_0001);          // off-subnet target

    pulse(1'b0, '0, '0, 1'b1);
    for (int i = 41; i <= 45; i++) pulse(1'b1, NET + 32'(i), 48'h0200_0000_0000 + 48'(i), 1'b0);
    for (int i = 42; i <= 45; i++) request(NET + 32'(i), 1, 0, '0);
    request(NET + 32'd41, 2, 0, 48'h0200_0000_0141);           // evicted entry misses
    pulse(1'b1, NET + 32'd43, 48'h0A0B_0C0D_0E0F, 1'b0);
    pulse(1'b1, 32'd0, 48'h0123_4567_89AB, 1'b0);
    request(NET + 32'd43, 1, 0, '0);
    request(NET + 32'd44, 1, 10, '0);                          // ready held low

    pulse(1'b1, NET + 32'd50, 48'h0200_0000_0050, 1'b1);       // clear beats update
    request(NET + 32'd43, 2, 0, 48'h0200_0000_0243);
    request(NET + 32'd50, 2, 0, 48'h0200_0000_0250);

    // Reset while waiting for a reply.
    pulse(1'b1, NET + 32'd60, 48'h0200_0000_0060, 1'b0);
    cur_target = NET + 32'd61;
    txn_q = 0;
    arp_request_ip = NET + 32'd61;
    arp_request_valid = 1'b1;
    tick();
    arp_request_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(query_valid && query_ready) && n < 100);
    if (!query_valid) timeout("query_before_rst");
    repeat (5) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_reset_outputs();
    tick();
    release_reset();
    m_ip.delete();
    m_mac.delete();
    q0 = q_total;
    r0 = resp_cnt;
    repeat (40) @(negedge clk);
    check("no_query_after_rst", 64'(q_total - q0), 64'(0));
    check("no_resp_after_rst", 64'(resp_cnt - r0), 64'(0));
    tick();
    request(NET + 32'd60, 2, 0, 48'h0200_0000_0360);           // cache was invalidated

    for (int t = 0; t < 60; t++) begin
      n = $urandom_range(0, 99);
      if (n < 30) pulse(1'b1, NET + 32'd20 + 32'($urandom_range(0, 7)), rand_mac(), 1'b0);
      else if (n < 34) pulse(1'b0, '0, '0, 1'b1);
      n = $urandom_range(0, 99);
      if (n < 6)       ip = NET + 32'd255;
      else if (n < 14) ip = 32'h0A00_0000 + 32'($urandom_range(1, 4));
      else             ip = NET + 32'd20 + 32'($urandom_range(0, 7));
      n = $urandom_range(0, 9);
      mac = rand_mac();
      request(ip, (n == 0) ? 0 : ((n < 7) ? 1 : 2), $urandom_range(0, 3), mac);
    end

    repeat (4) tick();
    check("scoreboard_empty", 64'(exp_mac.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
